// File: rtl/ex_mul_pkg.sv
// ex_mul_pkg: shared types and default sizing for the iterative multiplier.
package ex_mul_pkg;
  localparam int XLEN_DEF = 32;
  localparam int BPC_DEF = 4;
  localparam int TAG_W_DEF = 5;
  localparam int MUL_STEPS = XLEN_DEF / BPC_DEF;
  localparam int MUL_STEP_W = $clog2(MUL_STEPS);
  typedef enum logic [1:0] {MUL = 2'd0, MULH = 2'd1, MULHSU = 2'd2, MULHU = 2'd3} mul_op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mul_state_t;
endpackage

// File: rtl/mul_iter_step.sv
// mul_iter_step: one shift-add step, folding BPC multiplier bits into the accumulator.
module mul_iter_step #(
  parameter int XLEN = 32,
  parameter int BPC = 4
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [2*XLEN-1:0] a_sh_i,
  input  logic [BPC-1:0]    b_bits_i,
  output logic [2*XLEN-1:0] acc_o
);
  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < BPC; i++) acc_o = acc_o + (b_bits_i[i] ? a_sh_i << i : '0);
  end
endmodule

// File: rtl/mul_iter.sv
// mul_iter: iterative RV32M multiplier, BPC bits per cycle, valid/ready on both sides.
module mul_iter import ex_mul_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int BPC = BPC_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [XLEN-1:0]  in_a_i,
  input  logic [XLEN-1:0]  in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_result_o,
  output logic [TAG_W-1:0] out_tag_o
);
  localparam int STEPS = XLEN / BPC;
  localparam int CW = $clog2(STEPS);
  localparam int SHW = $clog2(XLEN);
  localparam int LB = $clog2(BPC);
  mul_state_t state_q, state_d;
  mul_op_t op_q, op_in;
  logic [TAG_W-1:0] tag_q, otag_q;
  logic [XLEN-1:0] a_q, b_q, res_q, mag_a, mag_b;
  logic neg_q, sign_a, sign_b, zero, last, accept;
  logic [CW-1:0] cnt_q;
  logic [SHW-1:0] sh;
  logic [2*XLEN-1:0] acc_q, acc_d, a_sh, prod;

  assign op_in = mul_op_t'(in_op_i);
  assign sign_a = op_in != MULHU && in_a_i[XLEN-1];
  assign sign_b = (op_in == MUL || op_in == MULH) && in_b_i[XLEN-1];
  assign mag_a = sign_a ? -in_a_i : in_a_i;
  assign mag_b = sign_b ? -in_b_i : in_b_i;
  assign zero = in_a_i == '0 || in_b_i == '0;
  assign accept = state_q == IDLE && in_valid_i && !flush_i;
  assign last = cnt_q == CW'(STEPS - 1);
  assign sh = SHW'(cnt_q) << LB;
  assign a_sh = {{XLEN{1'b0}}, a_q} << sh;
  assign prod = neg_q ? ~acc_d + (2*XLEN)'(1) : acc_d;

  mul_iter_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
    .acc_i   (acc_q),
    .a_sh_i  (a_sh),
    .b_bits_i(b_q[sh +: BPC]),
    .acc_o   (acc_d)
  );

  always_ff @(posedge clock_i) state_q <= !reset_n_i ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = IDLE;
    else if (state_q == IDLE) state_d = in_valid_i ? BUSY : IDLE;
    else if (state_q == BUSY) state_d = last ? DONE : BUSY;
    else state_d = out_ready_i ? IDLE : DONE;
  end

  always_comb begin
    in_ready_o = state_q == IDLE;
    out_valid_o = state_q == DONE;
  end

  // A zero operand jumps straight to the final step: the product is 0 either way
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      otag_q <= '0;
    end else if (accept) begin
      op_q <= op_in;
      tag_q <= in_tag_i;
      a_q <= mag_a;
      b_q <= mag_b;
      neg_q <= sign_a ^ sign_b;
      acc_q <= '0;
      cnt_q <= zero ? CW'(STEPS - 1) : '0;
    end else if (state_q == BUSY && !flush_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        res_q <= op_q == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        otag_q <= tag_q;
      end
    end
  end

  assign out_result_o = res_q;
  assign out_tag_o = otag_q;
endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: directed and random checks of mul_iter against a 64-bit reference product.
module tb_mul_iter;
  logic clock = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [1:0] in_op = 0;
  logic [31:0] in_a = 0, in_b = 0, out_result;
  logic [4:0] in_tag = 0, out_tag;
  int n_cmp = 0, n_bad = 0;

  mul_iter dut (
    .clock_i(clock), .reset_n_i(reset_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result), .out_tag_o(out_tag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    step();
    in_valid = 0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic pop;
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic run(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b, tag);
    wait_valid(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_res"}, out_result, exp);
    chk({nm, "_tag"}, 32'(out_tag), 32'(tag));
    pop();
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'd3) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (op <= 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    int s;
    s = $urandom_range(0, 7);
    return s == 0 ? 32'h0 : s == 1 ? 32'h8000_0000 : s == 2 ? 32'hFFFF_FFFF : s == 3 ? 32'h1 : $urandom;
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [1:0] op;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", out_result, 0);
    chk("rst_tag", 32'(out_tag), 0);
    reset_n = 1;
    in_valid = 1; flush = 1; in_a = 7; in_b = 6;
    step();
    in_valid = 0; flush = 0;
    chk("flush_blocks_accept", 32'(in_ready), 1);
    run("mul_7x6", 2'd0, 7, 6, 5'h0A, 42, 8);
    chk("idle_after_pop", 32'(in_ready), 1);
    run("mulh_min", 2'd1, 32'h8000_0000, 32'h8000_0000, 5'h01, 32'h4000_0000, 8);
    run("mulhu_min", 2'd3, 32'h8000_0000, 32'h8000_0000, 5'h02, 32'h4000_0000, 8);
    run("mulhsu_ones", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 32'hFFFF_FFFF, 8);
    run("mul_zero_a", 2'd0, 0, 32'h1234_5678, 5'h04, 0, 1);
    run("mulh_zero_b", 2'd1, 5, 0, 5'h05, 0, 1);
    begin
      int lat;
      issue(2'd0, 3, 5, 5'h06);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
        step();
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_result", out_result, 15);
        chk("bp_in_ready", 32'(in_ready), 0);
      end
      pop();
      chk("bp_release_ready", 32'(in_ready), 1);
      chk("bp_release_valid", 32'(out_valid), 0);
      chk("bp_result_held", out_result, 15);
    end
    issue(2'd0, 100, 100, 5'h07);
    step(); step();
    flush = 1;
    step();
    flush = 0;
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_valid", 32'(out_valid), 0);
    for (int i = 0; i < 10; i++) step();
    chk("flush_no_output", 32'(out_valid), 0);
    chk("flush_result_kept", out_result, 15);
    run("mul_3xm4", 2'd0, 3, 32'hFFFF_FFFC, 5'h08, 32'hFFFF_FFF4, 8);
    issue(2'd0, 9, 9, 5'h1F);
    step(); step(); step();
    reset_n = 0;
    step();
    reset_n = 1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_tag", 32'(out_tag), 0);
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      run("rand", op, a, b, 5'($urandom), ref_mul(op, a, b), (a == 0 || b == 0) ? 1 : 8);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
